othello_move_engine: RTL and testbench

Validates and executes one Othello move for the player selected by the main controller. It sits directly downstream of the main controller: it consumes the controller's `new_move`/`player` request and the cursor position, and produces the `ack` that advances the turn. It scans all eight directions from the target cell over a synchronous board RAM, flips bracketed discs, places the new disc, then acknowledges. It signals rejection of illegal moves.

---
 rtl/othello_pkg.sv | 34 +++
 rtl/othello_step_calc.sv | 32 +++
 rtl/othello_move_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_othello_move_engine.sv | 443 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/othello_pkg.sv
// Shared cell encodings, direction tables and FSM states for the
// Othello move engine. Optional feature macro: OTHELLO_FLIP_COUNT_EN.
package othello_pkg;

  localparam int BOARD_DIM = 8;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  // Index = direction: N, NE, E, SE, S, SW, W, NW
  localparam logic signed [1:0] DIR_DX [8] = '{
    2'sd0, 2'sd1, 2'sd1, 2'sd1,
    2'sd0, -2'sd1, -2'sd1, -2'sd1
  };
  localparam logic signed [1:0] DIR_DY [8] = '{
    -2'sd1, -2'sd1, 2'sd0, 2'sd1,
    2'sd1, 2'sd1, 2'sd0, -2'sd1
  };

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_TGT,
    S_CHK_TGT,
    S_STEP,
    S_CHK,
    S_FLIP,
    S_PLACE,
    S_ACK,
    S_DONE_WAIT,
    S_REJECT
  } state_e;

endpackage

// File: rtl/othello_step_calc.sv
// Cell at target + k*(dx, dy) for one direction, with an
// in-board flag and the {y, x} board address.
module othello_step_calc
  import othello_pkg::*;
(
  input  logic [2:0] x_i,
  input  logic [2:0] y_i,
  input  logic [2:0] dir_i,
  input  logic [3:0] k_i,
  output logic       inb_o,
  output logic [5:0] addr_o
);

  logic signed [5:0] k_s;
  logic signed [5:0] dx_s;
  logic signed [5:0] dy_s;
  logic signed [5:0] px;
  logic signed [5:0] py;

  always_comb begin
    k_s  = $signed({2'b00, k_i});
    dx_s = {{4{DIR_DX[dir_i][1]}}, DIR_DX[dir_i]};
    dy_s = {{4{DIR_DY[dir_i][1]}}, DIR_DY[dir_i]};
    px   = $signed({3'b000, x_i}) + dx_s * k_s;
    py   = $signed({3'b000, y_i}) + dy_s * k_s;
    // Negative values wrap to large unsigned ones and fail the bound
    inb_o = ($unsigned(px) < 6'(BOARD_DIM))
         && ($unsigned(py) < 6'(BOARD_DIM));
    addr_o = {py[2:0], px[2:0]};
  end

endmodule

// File: rtl/othello_move_engine.sv
// Validates and applies one Othello move over a synchronous board RAM.
// Define OTHELLO_FLIP_COUNT_EN to add the flip_count output.
module othello_move_engine
  import othello_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              new_move,
  input  logic              player,
  input  logic [2:0]        cursor_x,
  input  logic [2:0]        cursor_y,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [1:0]        mem_wdata,
  input  logic [1:0]        mem_rdata,
  output logic              ack,
  output logic              invalid,
`ifdef OTHELLO_FLIP_COUNT_EN
  output logic [5:0]        flip_count,
`endif
  output logic              busy
);

  state_e     state_q;
  logic [2:0] x_q;
  logic [2:0] y_q;
  logic       player_q;
  logic [2:0] dir_q;
  logic [2:0] cnt_q;
  logic [2:0] flip_k_q;
  logic       any_flip_q;
  logic       step_inb_q;
  logic [5:0] addr_q;
  logic       we_q;
  logic [1:0] wdata_q;
  logic       ack_q;
  logic       inv_q;
  logic       busy_q;
`ifdef OTHELLO_FLIP_COUNT_EN
  logic [5:0] total_q;
  logic [5:0] flip_count_q;
`endif

  logic [1:0] own_c;
  logic [1:0] opp_c;
  logic       is_own;
  logic       is_opp;
  logic       go_end;
  logic       last_dir;
  logic       final_flip;
  logic [2:0] calc_dir;
  logic [3:0] calc_k;
  logic       calc_inb;
  logic [5:0] calc_addr;

  othello_step_calc u_step (
    .x_i    (x_q),
    .y_i    (y_q),
    .dir_i  (calc_dir),
    .k_i    (calc_k),
    .inb_o  (calc_inb),
    .addr_o (calc_addr)
  );

  // calc_* selects the cell the next registered address will point at
  always_comb begin
    own_c  = player_q ? CELL_WHITE : CELL_BLACK;
    opp_c  = player_q ? CELL_BLACK : CELL_WHITE;
    is_own = mem_rdata == own_c;
    is_opp = mem_rdata == opp_c;
    go_end = 1'b0;
    unique case (state_q)
      S_STEP:  go_end = !step_inb_q;
      S_CHK:   go_end = !is_opp && !(is_own && cnt_q != 3'd0);
      S_FLIP:  go_end = flip_k_q == cnt_q;
      default: go_end = 1'b0;
    endcase
    last_dir   = dir_q == 3'd7;
    final_flip = any_flip_q || state_q == S_FLIP;
    calc_dir   = dir_q;
    calc_k     = 4'd1;
    if (go_end)
      calc_dir = dir_q + 3'd1;
    else if (state_q == S_CHK_TGT)
      calc_dir = 3'd0;
    else if (state_q == S_CHK && is_opp)
      calc_k = {1'b0, cnt_q} + 4'd2;
    else if (state_q == S_FLIP)
      calc_k = {1'b0, flip_k_q} + 4'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      x_q        <= 3'd0;
      y_q        <= 3'd0;
      player_q   <= 1'b0;
      dir_q      <= 3'd0;
      cnt_q      <= 3'd0;
      flip_k_q   <= 3'd0;
      any_flip_q <= 1'b0;
      step_inb_q <= 1'b0;
      addr_q     <= 6'd0;
      we_q       <= 1'b0;
      wdata_q    <= 2'd0;
      ack_q      <= 1'b0;
      inv_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef OTHELLO_FLIP_COUNT_EN
      total_q      <= 6'd0;
      flip_count_q <= 6'd0;
`endif
    end else begin
      ack_q <= 1'b0;
      inv_q <= 1'b0;
      we_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: if (new_move) begin
          x_q      <= cursor_x;
          y_q      <= cursor_y;
          player_q <= player;
          addr_q   <= {cursor_y, cursor_x};
          busy_q   <= 1'b1;
          state_q  <= S_RD_TGT;
        end
        S_RD_TGT: state_q <= S_CHK_TGT;
        S_CHK_TGT: begin
          if (mem_rdata == CELL_BLACK || mem_rdata == CELL_WHITE) begin
            inv_q   <= 1'b1;
            state_q <= S_REJECT;
          end else begin
            dir_q      <= 3'd0;
            cnt_q      <= 3'd0;
            any_flip_q <= 1'b0;
`ifdef OTHELLO_FLIP_COUNT_EN
            total_q    <= 6'd0;
`endif
            step_inb_q <= calc_inb;
            if (calc_inb) addr_q <= calc_addr;
            state_q    <= S_STEP;
          end
        end
        S_STEP: if (step_inb_q) state_q <= S_CHK;
        S_CHK: begin
          unique case (1'b1)
            is_opp: begin
              cnt_q      <= cnt_q + 3'd1;
              step_inb_q <= calc_inb;
              if (calc_inb) addr_q <= calc_addr;
              state_q    <= S_STEP;
            end
            is_own && cnt_q != 3'd0: begin
              flip_k_q <= 3'd1;
              addr_q   <= calc_addr;
              we_q     <= 1'b1;
              wdata_q  <= own_c;
              state_q  <= S_FLIP;
            end
            default: ;
          endcase
        end
        S_FLIP: if (!go_end) begin
          flip_k_q <= flip_k_q + 3'd1;
          addr_q   <= calc_addr;
          we_q     <= 1'b1;
        end
        S_PLACE: begin
          ack_q   <= 1'b1;
`ifdef OTHELLO_FLIP_COUNT_EN
          flip_count_q <= total_q;
`endif
          state_q <= S_ACK;
        end
        S_ACK: state_q <= S_DONE_WAIT;
        S_DONE_WAIT: if (!new_move) begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        S_REJECT: begin
          if (!new_move || cursor_x != x_q || cursor_y != y_q) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
      if (go_end) begin
        cnt_q <= 3'd0;
        if (state_q == S_FLIP) begin
          any_flip_q <= 1'b1;
`ifdef OTHELLO_FLIP_COUNT_EN
          total_q    <= total_q + 6'(cnt_q);
`endif
        end
        if (!last_dir) begin
          dir_q      <= dir_q + 3'd1;
          step_inb_q <= calc_inb;
          if (calc_inb) addr_q <= calc_addr;
          state_q    <= S_STEP;
        end else if (final_flip) begin
          addr_q  <= {y_q, x_q};
          we_q    <= 1'b1;
          wdata_q <= own_c;
          state_q <= S_PLACE;
        end else begin
          inv_q   <= 1'b1;
          state_q <= S_REJECT;
        end
      end
    end
  end

  assign mem_addr  = ADDR_W'(addr_q);
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign ack       = ack_q;
  assign invalid   = inv_q;
  assign busy      = busy_q;
`ifdef OTHELLO_FLIP_COUNT_EN
  assign flip_count = flip_count_q;
`endif

endmodule

// File: tb/tb_othello_move_engine.sv
// Scoreboard bench for othello_move_engine: a reference move model
// queues expected RAM writes, a monitor pops and compares them.
`timescale 1ns/1ps
module tb_othello_move_engine;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       new_move = 1'b0;
  logic       player = 1'b0;
  logic [2:0] cursor_x = 3'd0;
  logic [2:0] cursor_y = 3'd0;
  logic [5:0] mem_addr;
  logic       mem_we;
  logic [1:0] mem_wdata;
  logic [1:0] mem_rdata;
  logic       ack;
  logic       invalid;
  logic       busy;
`ifdef OTHELLO_FLIP_COUNT_EN
  logic [5:0] flip_count;
`endif

  int total = 0;
  int bad = 0;
  int ack_cnt = 0;
  int inv_cnt = 0;
  int wr_cnt = 0;
  logic [1:0] ram [64];
  logic [7:0] exp_q [$];
  logic [7:0] exp_e;
  bit legal [64];
  int tdx [8] = '{0, 1, 1, 1, 0, -1, -1, -1};
  int tdy [8] = '{-1, -1, 0, 1, 1, 1, 0, -1};

  always #5 clock = ~clock;

  othello_move_engine #(.ADDR_W(6)) dut (
    .clock     (clock),
    .reset     (reset),
    .new_move  (new_move),
    .player    (player),
    .cursor_x  (cursor_x),
    .cursor_y  (cursor_y),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .ack       (ack),
    .invalid   (invalid),
`ifdef OTHELLO_FLIP_COUNT_EN
    .flip_count(flip_count),
`endif
    .busy      (busy)
  );

  always @(posedge clock) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      wr_cnt++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL write_unexpected got addr=%0d data=%0d required none",
                 mem_addr, mem_wdata);
      end else begin
        exp_e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== exp_e) begin
          bad++;
          $display("FAIL write_order got addr=%0d data=%0d required addr=%0d data=%0d",
                   mem_addr, mem_wdata, exp_e[7:2], exp_e[1:0]);
        end
      end
    end
    if (busy === 1'b1) begin
      total++;
      if (!legal[mem_addr]) begin
        bad++;
        $display("FAIL addr_range got addr=%0d required a scanned cell", mem_addr);
      end
    end
    if (ack === 1'b1) ack_cnt++;
    if (invalid === 1'b1) inv_cnt++;
    if (ack === 1'b1 && invalid === 1'b1) begin
      total++;
      bad++;
      $display("FAIL ack_and_invalid got both=1 required exclusive");
    end
  end

  task automatic begin_test();
    foreach (ram[i]) ram[i] = 2'b00;
    foreach (legal[i]) legal[i] = 1'b0;
    exp_q.delete();
    ack_cnt = 0;
    inv_cnt = 0;
    wr_cnt  = 0;
  endtask

  task automatic load_start();
    begin_test();
    ram[27] = 2'b10;
    ram[36] = 2'b10;
    ram[28] = 2'b01;
    ram[35] = 2'b01;
  endtask

  task automatic model_move(input int x, input int y, input bit pl, output int nf);
    logic [1:0] own;
    logic [1:0] opp;
    logic [1:0] c;
    logic [7:0] tmp [$];
    int cnt;
    int cx;
    int cy;
    own = pl ? 2'b10 : 2'b01;
    opp = pl ? 2'b01 : 2'b10;
    nf = 0;
    legal[y * 8 + x] = 1'b1;
    c = ram[y * 8 + x];
    if (c == 2'b01 || c == 2'b10) return;
    for (int d = 0; d < 8; d++) begin
      cnt = 0;
      for (int k = 1; k < 8; k++) begin
        cx = x + tdx[d] * k;
        cy = y + tdy[d] * k;
        if (cx < 0 || cx > 7 || cy < 0 || cy > 7) break;
        legal[cy * 8 + cx] = 1'b1;
        c = ram[cy * 8 + cx];
        if (c == opp) begin
          cnt++;
        end else begin
          if (c == own && cnt > 0)
            for (int j = 1; j <= cnt; j++)
              tmp.push_back({6'((y + tdy[d] * j) * 8 + x + tdx[d] * j), own});
          break;
        end
      end
    end
    nf = tmp.size();
    if (nf > 0) begin
      foreach (tmp[i]) exp_q.push_back(tmp[i]);
      exp_q.push_back({6'(y * 8 + x), own});
    end
  endtask

  task automatic start_move(input int x, input int y, input bit pl);
    int nf;
    model_move(x, y, pl, nf);
    cursor_x = 3'(x);
    cursor_y = 3'(y);
    player   = pl;
    new_move = 1'b1;
  endtask

  task automatic wait_result(output bit got_ack, output bit got_inv, output int cyc);
    got_ack = 1'b0;
    got_inv = 1'b0;
    cyc = 0;
    while (!got_ack && !got_inv && cyc < 300) begin
      @(posedge clock);
      #1;
      cyc++;
      got_ack = ack;
      got_inv = invalid;
    end
  endtask

  task automatic release_move(output bit idle);
    new_move = 1'b0;
    idle = 1'b0;
    for (int i = 0; i < 20 && !idle; i++) begin
      @(posedge clock);
      #1;
      idle = !busy;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    total++;
    if ({ack, invalid, busy, mem_we, mem_addr, mem_wdata} !== 12'd0) begin
      bad++;
      $display("FAIL reset_outputs got %b required 0",
               {ack, invalid, busy, mem_we, mem_addr, mem_wdata});
    end
`ifdef OTHELLO_FLIP_COUNT_EN
    total++;
    if (flip_count !== 6'd0) begin
      bad++;
      $display("FAIL reset_flip_count got %0d required 0", flip_count);
    end
`endif
    reset = 1'b1;
    @(posedge clock);
    #1;
  endtask

  task automatic test_basic_move();
    bit a, v, idle;
    int cyc;
    load_start();
    start_move(3, 2, 1'b0);
    wait_result(a, v, cyc);
    total++;
    if (a !== 1'b1 || v !== 1'b0) begin
      bad++;
      $display("FAIL basic_result got ack=%0d inv=%0d required ack=1 inv=0", a, v);
    end
    repeat (4) @(posedge clock);
    #1;
    total++;
    if (ack_cnt !== 1 || inv_cnt !== 0 || busy !== 1'b1) begin
      bad++;
      $display("FAIL basic_hold got acks=%0d invs=%0d busy=%0d required 1 0 1",
               ack_cnt, inv_cnt, busy);
    end
    total++;
    if (ram[27] !== 2'b01 || ram[19] !== 2'b01 || wr_cnt !== 2) begin
      bad++;
      $display("FAIL basic_board got r27=%0d r19=%0d writes=%0d required 1 1 2",
               ram[27], ram[19], wr_cnt);
    end
`ifdef OTHELLO_FLIP_COUNT_EN
    total++;
    if (flip_count !== 6'd1) begin
      bad++;
      $display("FAIL basic_flip_count got %0d required 1", flip_count);
    end
`endif
    release_move(idle);
    total++;
    if (!idle) begin
      bad++;
      $display("FAIL basic_release got busy=1 required 0");
    end
  endtask

  task automatic test_reject_then_move();
    bit a, v, idle;
    int cyc;
    int nf;
    load_start();
    start_move(0, 0, 1'b0);
    wait_result(a, v, cyc);
    total++;
    if (v !== 1'b1 || a !== 1'b0) begin
      bad++;
      $display("FAIL reject_result got ack=%0d inv=%0d required ack=0 inv=1", a, v);
    end
    repeat (4) @(posedge clock);
    #1;
    total++;
    if (inv_cnt !== 1 || busy !== 1'b1 || wr_cnt !== 0) begin
      bad++;
      $display("FAIL reject_hold got invs=%0d busy=%0d writes=%0d required 1 1 0",
               inv_cnt, busy, wr_cnt);
    end
    model_move(3, 2, 1'b0, nf);
    cursor_x = 3'd3;
    cursor_y = 3'd2;
    wait_result(a, v, cyc);
    total++;
    if (a !== 1'b1 || ram[19] !== 2'b01 || ram[27] !== 2'b01) begin
      bad++;
      $display("FAIL reject_retry got ack=%0d r19=%0d r27=%0d required 1 1 1",
               a, ram[19], ram[27]);
    end
    release_move(idle);
    total++;
    if (!idle || exp_q.size() != 0) begin
      bad++;
      $display("FAIL reject_release got idle=%0d pending=%0d required 1 0",
               idle, exp_q.size());
    end
  endtask

  task automatic test_occupied();
    bit a, v, idle;
    int cyc;
    load_start();
    start_move(3, 3, 1'b0);
    wait_result(a, v, cyc);
    total++;
    if (v !== 1'b1 || cyc > 3) begin
      bad++;
      $display("FAIL occupied_latency got inv=%0d cycles=%0d required 1 <=3", v, cyc);
    end
    release_move(idle);
    total++;
    if (!idle || wr_cnt !== 0) begin
      bad++;
      $display("FAIL occupied_writes got idle=%0d writes=%0d required 1 0", idle, wr_cnt);
    end
  endtask

  task automatic load_multi();
    begin_test();
    ram[36] = 2'b00;
    ram[28] = 2'b01;
    ram[20] = 2'b10;
    ram[35] = 2'b01;
    ram[34] = 2'b01;
    ram[33] = 2'b10;
    ram[27] = 2'b01;
    ram[18] = 2'b10;
  endtask

  task automatic test_multi_dir();
    bit a, v, idle;
    int cyc;
    load_multi();
    start_move(4, 4, 1'b1);
    wait_result(a, v, cyc);
    total++;
    if (a !== 1'b1 || wr_cnt !== 5) begin
      bad++;
      $display("FAIL multi_result got ack=%0d writes=%0d required 1 5", a, wr_cnt);
    end
    total++;
    if ({ram[28], ram[35], ram[34], ram[27], ram[36]} !== 10'b1010101010) begin
      bad++;
      $display("FAIL multi_board got %b required all white",
               {ram[28], ram[35], ram[34], ram[27], ram[36]});
    end
`ifdef OTHELLO_FLIP_COUNT_EN
    total++;
    if (flip_count !== 6'd4) begin
      bad++;
      $display("FAIL multi_flip_count got %0d required 4", flip_count);
    end
`endif
    release_move(idle);
  endtask

  task automatic test_corners();
    bit a, v, idle;
    int cyc;
    begin_test();
    ram[1]  = 2'b10;
    ram[2]  = 2'b10;
    ram[3]  = 2'b01;
    ram[8]  = 2'b10;
    ram[16] = 2'b01;
    start_move(0, 0, 1'b0);
    wait_result(a, v, cyc);
    total++;
    if (a !== 1'b1 || wr_cnt !== 4 || ram[0] !== 2'b01 || ram[2] !== 2'b01) begin
      bad++;
      $display("FAIL corner00 got ack=%0d writes=%0d r0=%0d r2=%0d required 1 4 1 1",
               a, wr_cnt, ram[0], ram[2]);
    end
    release_move(idle);
    begin_test();
    ram[62] = 2'b01;
    ram[61] = 2'b10;
    ram[55] = 2'b01;
    ram[47] = 2'b01;
    ram[39] = 2'b10;
    start_move(7, 7, 1'b1);
    wait_result(a, v, cyc);
    total++;
    if (a !== 1'b1 || wr_cnt !== 4 || ram[63] !== 2'b10 || ram[47] !== 2'b10) begin
      bad++;
      $display("FAIL corner77 got ack=%0d writes=%0d r63=%0d r47=%0d required 1 4 2 2",
               a, wr_cnt, ram[63], ram[47]);
    end
    release_move(idle);
  endtask

  task automatic test_reset_mid_flip();
    bit a, v, idle, seen;
    int cyc;
    int nf;
    load_multi();
    start_move(4, 4, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(posedge clock);
      #1;
      seen = mem_we;
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL midflip_reach got no write required a flip write");
    end
    reset = 1'b0;
    @(posedge clock);
    #1;
    total++;
    if (busy !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 6'd0 || ack !== 1'b0) begin
      bad++;
      $display("FAIL midflip_reset got busy=%0d we=%0d addr=%0d ack=%0d required 0 0 0 0",
               busy, mem_we, mem_addr, ack);
    end
    exp_q.delete();
    wr_cnt = 0;
    ack_cnt = 0;
    model_move(4, 4, 1'b1, nf);
    reset = 1'b1;
    wait_result(a, v, cyc);
    total++;
    if (a !== 1'b1 || wr_cnt !== 4 || ram[28] !== 2'b10) begin
      bad++;
      $display("FAIL midflip_restart got ack=%0d writes=%0d r28=%0d required 1 4 2",
               a, wr_cnt, ram[28]);
    end
`ifdef OTHELLO_FLIP_COUNT_EN
    total++;
    if (flip_count !== 6'd3) begin
      bad++;
      $display("FAIL midflip_flip_count got %0d required 3", flip_count);
    end
`endif
    release_move(idle);
    total++;
    if (!idle || exp_q.size() != 0) begin
      bad++;
      $display("FAIL midflip_release got idle=%0d pending=%0d required 1 0",
               idle, exp_q.size());
    end
  endtask

  initial begin
    foreach (ram[i]) ram[i] = 2'b00;
    test_reset();
    test_basic_move();
    test_reject_then_move();
    test_occupied();
    test_multi_dir();
    test_corners();
    test_reset_mid_flip();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
